// File: rtl/edge_window_monitor.sv
// edge_window_monitor: synchronizes two async signals, counts edges/coincidence per window, emits records on valid/ready
module edge_window_monitor #(
   parameter int CNT_W       = 8,
   parameter int WIN_LEN     = 100,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_c,
   input  logic             sig_d,
   input  logic             enable,
   input  logic             rec_ready,
   output logic             rec_valid,
   output logic [CNT_W-1:0] rec_c_edges,
   output logic [CNT_W-1:0] rec_d_edges,
   output logic [CNT_W-1:0] rec_both,
   output logic             rec_partial,
   output logic             drop_flag,
   input  logic             clr_drop
);
   localparam int IW = $clog2(WIN_LEN);
   localparam logic [CNT_W-1:0] MAX = '1;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] sync_c, sync_d;
   logic prev_c, prev_d, s_c, s_d, edge_c, edge_d, last, snap, xfer;
   logic [CNT_W-1:0] cnt_c, cnt_d, cnt_b, cnt_c_nx, cnt_d_nx, cnt_b_nx;
   logic [CNT_W-1:0] sum_c, sum_d, sum_b, snap_c, snap_d, snap_b;
   logic [IW-1:0] win_idx, win_idx_nx;
   assign s_c    = sync_c[SYNC_STAGES-1];
   assign s_d    = sync_d[SYNC_STAGES-1];
   assign edge_c = s_c & ~prev_c;
   assign edge_d = s_d & ~prev_d;
   assign sum_c  = cnt_c + CNT_W'(edge_c && cnt_c != MAX);
   assign sum_d  = cnt_d + CNT_W'(edge_d && cnt_d != MAX);
   assign sum_b  = cnt_b + CNT_W'(s_c && s_d && cnt_b != MAX);
   assign last   = win_idx == IW'(WIN_LEN - 1);
   assign snap_c = (state == RUN) ? sum_c : cnt_c;
   assign snap_d = (state == RUN) ? sum_d : cnt_d;
   assign snap_b = (state == RUN) ? sum_b : cnt_b;
   assign xfer   = rec_valid & rec_ready;
   // Synchronizers and edge history run in every state so re-enable never fakes an edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync_c <= '0;
         sync_d <= '0;
         prev_c <= 1'b0;
         prev_d <= 1'b0;
      end else begin
         sync_c <= {sync_c[SYNC_STAGES-2:0], sig_c};
         sync_d <= {sync_d[SYNC_STAGES-2:0], sig_d};
         prev_c <= s_c;
         prev_d <= s_d;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         cnt_c   <= '0;
         cnt_d   <= '0;
         cnt_b   <= '0;
         win_idx <= '0;
      end else begin
         state   <= state_nx;
         cnt_c   <= cnt_c_nx;
         cnt_d   <= cnt_d_nx;
         cnt_b   <= cnt_b_nx;
         win_idx <= win_idx_nx;
      end
   always_comb begin
      state_nx   = state;
      cnt_c_nx   = '0;
      cnt_d_nx   = '0;
      cnt_b_nx   = '0;
      win_idx_nx = '0;
      snap       = 1'b0;
      case (state)
         IDLE: state_nx = enable ? RUN : IDLE;
         RUN: begin
            if (!enable) begin
               state_nx   = FLUSH;
               cnt_c_nx   = cnt_c;
               cnt_d_nx   = cnt_d;
               cnt_b_nx   = cnt_b;
               win_idx_nx = win_idx;
            end else if (last) begin
               snap = 1'b1;
            end else begin
               cnt_c_nx   = sum_c;
               cnt_d_nx   = sum_d;
               cnt_b_nx   = sum_b;
               win_idx_nx = win_idx + IW'(1);
            end
         end
         FLUSH: begin
            snap     = win_idx != '0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   // A snapshot only lands if the output slot is free or being emptied this cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rec_valid   <= 1'b0;
         rec_c_edges <= '0;
         rec_d_edges <= '0;
         rec_both    <= '0;
         rec_partial <= 1'b0;
         drop_flag   <= 1'b0;
      end else begin
         if (snap && (!rec_valid || xfer)) begin
            rec_valid   <= 1'b1;
            rec_c_edges <= snap_c;
            rec_d_edges <= snap_d;
            rec_both    <= snap_b;
            rec_partial <= state == FLUSH;
         end else if (xfer) begin
            rec_valid <= 1'b0;
         end
         if (snap && rec_valid && !xfer) drop_flag <= 1'b1;
         else if (clr_drop) drop_flag <= 1'b0;
      end
endmodule

// File: tb/tb_edge_window_monitor.sv
// tb_edge_window_monitor: directed self-checking bench for edge_window_monitor
module tb_edge_window_monitor;
   localparam int CNT_W = 4;
   logic clk = 1'b0, rst_n = 1'b0, sig_c = 1'b0, sig_d = 1'b0, enable = 1'b0;
   logic rec_ready = 1'b0, clr_drop = 1'b0;
   logic rec_valid, rec_partial, drop_flag;
   logic [CNT_W-1:0] rec_c_edges, rec_d_edges, rec_both;
   int n_chk = 0, n_fail = 0;

   edge_window_monitor #(.CNT_W(CNT_W), .WIN_LEN(20), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sig_c(sig_c), .sig_d(sig_d), .enable(enable),
      .rec_ready(rec_ready), .rec_valid(rec_valid), .rec_c_edges(rec_c_edges),
      .rec_d_edges(rec_d_edges), .rec_both(rec_both), .rec_partial(rec_partial),
      .drop_flag(drop_flag), .clr_drop(clr_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int k = 1);
      repeat (k) @(negedge clk);
   endtask

   task automatic idle_gap();
      enable = 1'b0;
      rec_ready = 1'b1;
      sig_c = 1'b0;
      sig_d = 1'b0;
      tick(30);
   endtask

   task automatic wait_valid(input int max);
      for (int i = 0; i < max && !rec_valid; i++) tick();
      chk("wait_valid", int'(rec_valid), 1);
   endtask

   task automatic chk_rec(input string tag, input int c, input int d, input int b, input int p);
      chk({tag, "_valid"}, int'(rec_valid), 1);
      chk({tag, "_c"}, int'(rec_c_edges), c);
      chk({tag, "_d"}, int'(rec_d_edges), d);
      chk({tag, "_both"}, int'(rec_both), b);
      chk({tag, "_partial"}, int'(rec_partial), p);
   endtask

   initial begin
      tick(2);
      chk("rst_valid", int'(rec_valid), 0);
      chk("rst_c", int'(rec_c_edges), 0);
      chk("rst_drop", int'(drop_flag), 0);
      rst_n = 1'b1;
      tick(5);
      // Test 1: async reset while a record is pending
      enable = 1'b1;
      for (int n = 0; n < 25; n++) begin
         sig_c = (n == 2);
         tick();
      end
      chk_rec("t1_pre", 1, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_rst_valid", int'(rec_valid), 0);
      chk("t1_rst_c", int'(rec_c_edges), 0);
      chk("t1_rst_partial", int'(rec_partial), 0);
      chk("t1_rst_drop", int'(drop_flag), 0);
      tick();
      enable = 1'b0;
      rst_n = 1'b1;
      tick(25);
      chk("t1_idle_no_rec", int'(rec_valid), 0);
      // Test 2: three C pulses in window 0
      rec_ready = 1'b1;
      enable = 1'b1;
      for (int n = 0; n < 21; n++) begin
         sig_c = (n == 2 || n == 6 || n == 10);
         tick();
      end
      chk_rec("t2", 3, 0, 0, 0);
      tick();
      chk("t2_one_cycle", int'(rec_valid), 0);
      idle_gap();
      // Test 3: coincidence count saturates
      sig_c = 1'b1;
      sig_d = 1'b1;
      tick(5);
      enable = 1'b1;
      wait_valid(30);
      chk_rec("t3", 0, 0, 15, 0);
      idle_gap();
      // Test 4: backpressure drop, clr_drop, then drain
      rec_ready = 1'b0;
      chk("t4_drop_init", int'(drop_flag), 0);
      enable = 1'b1;
      for (int n = 0; n < 45; n++) begin
         sig_c = (n inside {2, 5, 20, 23, 26, 29, 32});
         if (n == 42) enable = 1'b0;
         tick();
      end
      chk_rec("t4_hold", 2, 0, 0, 0);
      chk("t4_drop", int'(drop_flag), 1);
      clr_drop = 1'b1;
      tick();
      clr_drop = 1'b0;
      chk("t4_clr", int'(drop_flag), 0);
      chk_rec("t4_after_clr", 2, 0, 0, 0);
      rec_ready = 1'b1;
      tick();
      chk("t4_drain", int'(rec_valid), 0);
      idle_gap();
      // Test 5: accept and snapshot in the same cycle
      rec_ready = 1'b0;
      enable = 1'b1;
      for (int n = 0; n < 40; n++) begin
         sig_c = (n inside {3, 22, 25, 28});
         tick();
      end
      chk_rec("t5_old", 1, 0, 0, 0);
      rec_ready = 1'b1;
      tick();
      chk_rec("t5_new", 3, 0, 0, 0);
      chk("t5_drop", int'(drop_flag), 0);
      idle_gap();
      // Test 6: partial flush, then re-enable with D already high
      enable = 1'b1;
      for (int n = 0; n < 10; n++) begin
         sig_d = (n == 1 || n == 4 || n >= 8);
         if (n == 8) enable = 1'b0;
         tick();
      end
      chk_rec("t6_partial", 0, 2, 0, 1);
      tick(5);
      enable = 1'b1;
      tick();
      wait_valid(30);
      chk_rec("t6_reenable", 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
